// File: rtl/vigna_mem_responder.sv
// vigna_mem_responder: word-organised on-chip memory acting as the responder
// on one vigna valid/ready port. A request is accepted in IDLE, held for
// WAIT_CYCLES wait states, committed, and answered with a one-cycle ready
// pulse. Accesses outside the window [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH)
// complete with bus_err set instead of hanging the core.
//
// Optional feature macro: VIGNA_RESP_LANE_SHIFT_EN
//   defined     - write strobes/data are shifted up by addr[1:0] bytes before
//                 commit, and read data is shifted down by addr[1:0] bytes.
//   not defined - addr[1:0] is ignored; the word is used as presented.
module vigna_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  output logic        ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        bus_err
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic [3:0]            sel_strb;
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  commit;
  logic                  do_write;
  logic [3:0]            wr_strb;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;

  // With zero wait states the commit happens on the accepting edge itself,
  // so the live request inputs are used in IDLE and the latched copy later.
  always_comb begin
    sel_addr  = req_addr;
    sel_wdata = req_wdata;
    sel_strb  = req_strb;
    if (state == ST_IDLE) begin
      sel_addr  = addr;
      sel_wdata = wdata;
      sel_strb  = wstrb;
    end
  end

  assign offset   = sel_addr - BASE_ADDR;
  assign in_range = ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign idx      = offset[ADDR_WIDTH+1:2];

  // Commit is gated by reset so an abort can never sneak a write through.
  assign commit   = !reset &&
                    (((state == ST_IDLE) && valid && (WAIT_CYCLES == 0)) ||
                     ((state == ST_WAIT) && (cnt == 4'd1)));
  assign do_write = commit && in_range && (sel_strb != 4'b0000);

`ifdef VIGNA_RESP_LANE_SHIFT_EN
  assign wr_strb = sel_strb << sel_addr[1:0];
  assign wr_data = sel_wdata << {sel_addr[1:0], 3'b000};
  assign rd_word = mem[idx] >> {sel_addr[1:0], 3'b000};
`else
  assign wr_strb = sel_strb;
  assign wr_data = sel_wdata;
  assign rd_word = mem[idx];
`endif

  // Memory array: byte-lane writes on commit, deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Control FSM, request latch and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      req_strb  <= 4'd0;
    end else begin
      ready   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_strb  <= wstrb;
            cnt       <= WAIT_LOAD;
            state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (commit) begin
        ready   <= 1'b1;
        bus_err <= !in_range;
        if (in_range && (sel_strb == 4'b0000)) begin
          rdata <= rd_word;
        end else begin
          rdata <= 32'd0;
        end
      end
    end
  end

endmodule
